// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with 3-sample majority voting, optional parity and stop check.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [1:0]            samp_q, samp_d;
  logic [5:0]            presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic [5:0]            half, presc_in;
  logic                  last, decide, bit_v;
  assign presc_in = (PRESCALE == 6'd8 || PRESCALE == 6'd16 || PRESCALE == 6'd32) ? PRESCALE : 6'd8;
  assign half     = presc_q >> 1;
  assign last     = edge_cnt_q == presc_q - 6'd1;
  assign decide   = state_q != IDLE && edge_cnt_q == half + 6'd1;
  // majority of the two stored samples and the live third sample
  assign bit_v    = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = last ? 6'd0 : edge_cnt_q + 6'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    p_data_d   = p_data_q;
    samp_d[0]  = edge_cnt_q == half - 6'd1 ? RX_IN : samp_q[0];
    samp_d[1]  = edge_cnt_q == half ? RX_IN : samp_q[1];
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_bad_d  = par_bad_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    case (state_q)
      IDLE: begin
        edge_cnt_d = RX_IN ? 6'd0 : 6'd1;
        if (!RX_IN) begin
          state_d   = START;
          presc_d   = presc_in;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bad_d = 1'b0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (decide && bit_v) begin
          state_d    = IDLE;
          edge_cnt_d = 6'd0;
        end else if (last) state_d = DATA;
      end
      DATA: begin
        if (decide) shift_d = {bit_v, shift_q[DATA_WIDTH-1:1]};
        if (last) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (decide) par_bad_d = bit_v != (par_typ_q ? ~^shift_q : ^shift_q);
        if (last) state_d = STOP;
      end
      STOP: begin
        if (decide) begin
          state_d    = IDLE;
          edge_cnt_d = 6'd0;
          dv_d       = !par_bad_q && bit_v;
          pe_d       = par_bad_q;
          se_d       = !bit_v;
          p_data_d   = (!par_bad_q && bit_v) ? shift_q : p_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      p_data_q   <= '0;
      samp_q     <= '0;
      presc_q    <= 6'd8;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      p_data_q   <= p_data_d;
      samp_q     <= samp_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bad_q  <= par_bad_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end
  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with hand-computed pulse timing, flags and data for uart_rx.
module tb_uart_rx;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID, PAR_ERR, STP_ERR;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         npulse = 0;
  int         last_cyc = 0;
  logic       last_dv = 1'b0, last_pe = 1'b0, last_se = 1'b0;
  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // every cycle with any result pulse is logged; cyc here equals the edge index that produced it
  always @(negedge CLK) begin
    if (DATA_VALID || PAR_ERR || STP_ERR) begin
      npulse   = npulse + 1;
      last_cyc = cyc;
      last_dv  = DATA_VALID;
      last_pe  = PAR_ERR;
      last_se  = STP_ERR;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(negedge CLK);
  endtask
  task automatic frame(input string tag, input logic [7:0] d, input logic [5:0] ps, input int p,
                       input logic pen, input logic ptyp, input logic pbit, input logic sbit,
                       input int lat, input logic dv, input logic pe, input logic se,
                       input logic [7:0] pd);
    int n0, c0;
    n0 = npulse;
    c0 = cyc;
    PRESCALE = ps;
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    drive_bit(1'b0, p);
    PRESCALE = (ps == 6'd16) ? 6'd8 : 6'd16;
    PAR_EN   = ~pen;
    PAR_TYP  = ~ptyp;
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit(pbit, p);
    drive_bit(sbit, p);
    check({tag, " pulses"}, npulse - n0, 1);
    check({tag, " edge"}, last_cyc - c0, lat + 1);
    check({tag, " dv"}, last_dv, dv);
    check({tag, " par_err"}, last_pe, pe);
    check({tag, " stp_err"}, last_se, se);
    check({tag, " p_data"}, P_DATA, pd);
  endtask
  initial begin
    int n0, c0;
    repeat (3) @(negedge CLK);
    check("rst p_data", P_DATA, 0);
    check("rst dv", DATA_VALID, 0);
    check("rst par_err", PAR_ERR, 0);
    check("rst stp_err", STP_ERR, 0);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    frame("a5", 8'hA5, 6'd8, 8, 1'b1, 1'b0, 1'b0, 1'b1, 85, 1'b1, 1'b0, 1'b0, 8'hA5);
    frame("3c", 8'h3C, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b1, 153, 1'b1, 1'b0, 1'b0, 8'h3C);
    frame("odd", 8'h01, 6'd8, 8, 1'b1, 1'b1, 1'b1, 1'b1, 85, 1'b0, 1'b1, 1'b0, 8'h3C);
    frame("stp", 8'h5A, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 77, 1'b0, 1'b0, 1'b1, 8'h3C);
    drive_bit(1'b1, 12);
    frame("both", 8'h5A, 6'd8, 8, 1'b1, 1'b0, 1'b1, 1'b0, 85, 1'b0, 1'b1, 1'b1, 8'h3C);
    drive_bit(1'b1, 12);
    n0 = npulse;
    PRESCALE = 6'd8;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 20);
    check("glitch pulses", npulse - n0, 0);
    frame("55", 8'h55, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 77, 1'b1, 1'b0, 1'b0, 8'h55);
    frame("ps12", 8'hC3, 6'd12, 8, 1'b1, 1'b0, 1'b0, 1'b1, 85, 1'b1, 1'b0, 1'b0, 8'hC3);
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    n0 = npulse;
    c0 = cyc;
    drive_bit(1'b0, 80);
    drive_bit(1'b1, 20);
    check("low pulses", npulse - n0, 1);
    check("low edge", last_cyc - c0, 78);
    check("low stp_err", last_se, 1);
    check("low dv", last_dv, 0);
    check("low p_data", P_DATA, 8'hC3);
    frame("b2b1", 8'h12, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 77, 1'b1, 1'b0, 1'b0, 8'h12);
    frame("b2b2", 8'h34, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 77, 1'b1, 1'b0, 1'b0, 8'h34);
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    n0 = npulse;
    drive_bit(1'b0, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 3);
    RST = 1'b0;
    #1;
    check("abort p_data", P_DATA, 0);
    check("abort dv", DATA_VALID, 0);
    check("abort par_err", PAR_ERR, 0);
    check("abort stp_err", STP_ERR, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    drive_bit(1'b1, 30);
    check("abort pulses", npulse - n0, 0);
    frame("post", 8'h9E, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 77, 1'b1, 1'b0, 1'b0, 8'h9E);
    drive_bit(1'b1, 10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame, sent LSB first.
REQ-002 SHALL have port CLK, input, 1 bit: oversampling clock; all logic on rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port RX_IN, input, 1 bit: serial line, idle high; pre-synchronised externally.
REQ-005 SHALL have port PRESCALE, input, 6 bits: oversample ratio; legal values are 8, 16 and 32.
REQ-006 SHALL have port PAR_EN, input, 1 bit: 1 means a parity bit follows the data.
REQ-007 SHALL have port PAR_TYP, input, 1 bit: 0 means even parity, 1 means odd parity.
REQ-008 SHALL have port P_DATA, output, DATA_WIDTH bits: last correctly received byte.
REQ-009 SHALL have port DATA_VALID, output, 1 bit: one-cycle pulse marking a good frame.
REQ-010 SHALL have port PAR_ERR, output, 1 bit: one-cycle pulse marking a parity mismatch.
REQ-011 SHALL have port STP_ERR, output, 1 bit: one-cycle pulse marking a stop bit sampled as 0.

Function
REQ-012 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP; the encoding is free.
REQ-013 Start detection SHALL work as follows:
- Condition: in IDLE, RX_IN = 0 at a clock edge (the "detection edge", tick 0).
- Result: go to START with edge_cnt = 1.
- Also at the detection edge: latch PRESCALE, PAR_EN and PAR_TYP for the whole frame.
REQ-014 A latched PRESCALE value not in {8, 16, 32} SHALL be treated as 8.
REQ-015 Bit timing SHALL use edge_cnt:
- edge_cnt counts 0..P-1 within each bit period (P = latched prescale).
- Frame bit k occupies ticks k*P .. k*P+P-1 after the detection edge.
REQ-016 Bit sampling SHALL be the majority of 3 samples of RX_IN taken at edge_cnt = P/2-1, P/2 and P/2+1; the bit decision is registered at edge_cnt = P/2+1.
REQ-017 START SHALL handle the start bit as follows:
- Start bit decided 1 (glitch): return to IDLE at the decision edge; no output pulses.
- Start bit decided 0: go to DATA at edge_cnt = P-1.
REQ-018 DATA SHALL shift each decided bit into a shift register LSB-first and SHALL leave at edge_cnt = P-1 of data bit DATA_WIDTH-1:
- PAR_EN = 1: go to PARITY.
- PAR_EN = 0: go to STOP.
REQ-019 PARITY SHALL compare the decided bit with the parity computed over the received data (even: XOR; odd: XNOR), record any mismatch, then go to STOP at edge_cnt = P-1.
REQ-020 STOP SHALL return to IDLE at its decision edge, i.e. before the stop bit ends, so that a back-to-back start bit is detected.
REQ-021 The end-of-frame result SHALL be registered at the stop decision edge and last exactly one cycle:
- No parity error and no stop error: DATA_VALID = 1 and P_DATA = shift register.
- Parity error: PAR_ERR = 1.
- Stop bit decided 0: STP_ERR = 1.
- Both errors together: PAR_ERR and STP_ERR both = 1.
- Any error: DATA_VALID stays 0 and P_DATA holds its previous value.
REQ-022 Latency SHALL be: DATA_VALID is registered on rising edge k_stop*P + P/2 + 1 after the detection edge, where k_stop = DATA_WIDTH+2 with parity and DATA_WIDTH+1 without.
REQ-023 Changes on the PRESCALE, PAR_EN and PAR_TYP inputs during a frame SHALL have no effect on that frame.
REQ-024 RX_IN held low continuously SHALL produce a frame with STP_ERR, then restart detection from IDLE.

Reset
REQ-025 When RST = 0, the block SHALL immediately enter IDLE and clear edge_cnt, the bit counter, the shift register, P_DATA, DATA_VALID, PAR_ERR and STP_ERR.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, the next falling edge of RX_IN starts a new frame.

Verification
REQ-027 SHALL cover: P = 8, PAR_EN = 1, PAR_TYP = 0, frame 0xA5 with parity bit 0 and stop bit 1 -> DATA_VALID for one cycle at edge 85, P_DATA = 0xA5, no error pulses.
REQ-028 SHALL cover: P = 16, PAR_EN = 0, frame 0x3C -> DATA_VALID at edge 9*16+9 = 153, P_DATA = 0x3C.
REQ-029 SHALL cover: P = 8, PAR_EN = 1, PAR_TYP = 1, frame 0x01 sent with parity bit 1 (wrong) -> PAR_ERR pulse at edge 85, DATA_VALID = 0, P_DATA unchanged.
REQ-030 SHALL cover: stop bit driven 0 -> STP_ERR pulse, DATA_VALID = 0; with a bad parity bit as well, PAR_ERR and STP_ERR pulse in the same cycle.
REQ-031 SHALL cover: a 2-tick low glitch on idle RX_IN at P = 8 -> return to IDLE, no pulses; the next real frame 0x55 is received correctly.
REQ-032 SHALL cover: two back-to-back frames 0x12 and 0x34 with no idle gap, plus RST pulsed low during data bit 3 of a third frame -> DATA_VALID for 0x12 and for 0x34, no pulse for the aborted frame, and all outputs reading 0 immediately after reset.
